// File: rtl/aes_stream_engine.sv
// Streaming AES-128 engine: input FIFO, multicycle combinational core, ECB (and optional CBC) chaining.
// Define AES_CBC_EN to build CBC support (IV, chain register and XOR paths); default is ECB only.
module aes_stream_engine #(
  parameter int FIFO_DEPTH  = 4,
  parameter int CORE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic         encrypt,
  input  logic         cbc_mode,
  output logic         key_err,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CORE_CYCLES + 1);

  typedef logic [15:0][7:0]   blk_t;  // byte 15 is the first byte on the wire
  typedef logic [10:0][127:0] rk_t;
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic blk_t sub_bytes(input blk_t s, input logic inv);
    blk_t o;
    for (int i = 0; i < 16; i++) o[i] = inv ? inv_sbox(s[i]) : sbox(s[i]);
    return o;
  endfunction

  function automatic blk_t shift_rows(input blk_t s, input logic inv);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[15 - (r + 4 * c)] = s[15 - (r + 4 * ((inv ? c - r + 4 : c + r) % 4))];
    return o;
  endfunction

  function automatic blk_t mix_columns(input blk_t s, input logic inv);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[15 - 4 * c];
      a1 = s[14 - 4 * c];
      a2 = s[13 - 4 * c];
      a3 = s[12 - 4 * c];
      if (!inv) begin
        o[15 - 4 * c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[14 - 4 * c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[13 - 4 * c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[12 - 4 * c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end else begin
        o[15 - 4 * c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        o[14 - 4 * c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        o[13 - 4 * c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        o[12 - 4 * c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
    end
    return o;
  endfunction

  function automatic rk_t key_expand(input logic [127:0] key);
    logic [43:0][31:0] w;
    logic [31:0]       t;
    logic [7:0]        rcon;
    rk_t               rk;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    return rk;
  endfunction

  function automatic blk_t aes_encrypt(input blk_t pt, input rk_t rk);
    blk_t s;
    s = pt ^ rk[0];
    for (int r = 1; r < 10; r++) s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
    return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[10];
  endfunction

  function automatic blk_t aes_decrypt(input blk_t ct, input rk_t rk);
    blk_t s;
    s = ct ^ rk[10];
    for (int r = 9; r > 0; r--) s = mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r], 1'b1);
    return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[0];
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W:0]     count_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [128:0]       mem_q [FIFO_DEPTH];
  logic [127:0]       din_q, din_d, key_q, m_data_q, m_data_d;
  logic               last_q, last_d, enc_q, m_valid_q, m_valid_d, m_last_q, m_last_d, key_err_q;
  logic               push, pop, full, cfg_load;
  logic [127:0]       core_in, core_out, result;
  rk_t                round_keys;
`ifdef AES_CBC_EN
  logic [127:0]       iv_q, chain_q, chain_d;
  logic               cbc_q;
`else
  logic               unused_cbc;
  assign unused_cbc = ^{iv_in, cbc_mode};
`endif

  assign full     = count_q == (PTR_W + 1)'(FIFO_DEPTH);
  assign s_ready  = !full && !rst;
  assign busy     = (count_q != '0) || (state_q == CALC) || m_valid_q;
  assign push     = s_valid && s_ready;
  assign cfg_load = key_load && !busy;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign m_last   = m_last_q;
  assign key_err  = key_err_q;

  always_comb round_keys = key_expand(key_q);

  always_comb begin
    core_in = din_q;
`ifdef AES_CBC_EN
    if (cbc_q && enc_q) core_in = din_q ^ chain_q;
`endif
    if (enc_q) core_out = aes_encrypt(core_in, round_keys);
    else       core_out = aes_decrypt(core_in, round_keys);
    result = core_out;
`ifdef AES_CBC_EN
    if (cbc_q && !enc_q) result = core_out ^ chain_q;
`endif
  end

  // NOTE: every signal gets its default before the case, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    din_d     = din_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    pop       = 1'b0;
`ifdef AES_CBC_EN
    chain_d   = cfg_load ? iv_in : chain_q;
`endif
    case (state_q)
      IDLE: if (count_q != '0) pop = 1'b1;
      CALC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          m_valid_d = 1'b1;
          m_data_d  = result;
          m_last_d  = last_q;
          state_d   = OUT;
`ifdef AES_CBC_EN
          if (last_q)     chain_d = iv_q;  // next message restarts from the IV
          else if (cbc_q) chain_d = enc_q ? result : din_q;
`endif
        end
      end
      OUT: if (m_ready) begin
        m_valid_d = 1'b0;
        if (count_q != '0) pop = 1'b1;
        else               state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      din_d   = mem_q[rd_ptr_q][127:0];
      last_d  = mem_q[rd_ptr_q][128];
      cnt_d   = CNT_W'(CORE_CYCLES - 1);
      state_d = CALC;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      din_q     <= '0;
      last_q    <= 1'b0;
      key_q     <= '0;
      enc_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      key_err_q <= 1'b0;
`ifdef AES_CBC_EN
      iv_q      <= '0;
      chain_q   <= '0;
      cbc_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      din_q     <= din_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      key_err_q <= key_load && busy;
      count_q   <= count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (cfg_load) begin
        key_q <= key_in;
        enc_q <= encrypt;
`ifdef AES_CBC_EN
        iv_q  <= iv_in;
        cbc_q <= cbc_mode;
`endif
      end
`ifdef AES_CBC_EN
      chain_q <= chain_d;
`endif
    end
  end

  // NOTE: the queue storage has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_last, s_data};
  end
endmodule

// File: tb/tb_aes_stream_engine.sv
// Directed bench for aes_stream_engine: FIPS-197 / SP800-38A vectors, backpressure, key_err, reset.
// CBC vectors run only when AES_CBC_EN is defined.
module tb_aes_stream_engine;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] iv_in = '0;
  logic         encrypt = 1'b0;
  logic         cbc_mode = 1'b0;
  logic         key_err;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [127:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [127:0] m_data;
  logic         m_last;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  aes_stream_engine #(.FIFO_DEPTH(4), .CORE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .iv_in(iv_in),
    .encrypt(encrypt), .cbc_mode(cbc_mode), .key_err(key_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [127:0] k, input logic [127:0] iv, input logic enc, input logic cbc);
    key_in = k; iv_in = iv; encrypt = enc; cbc_mode = cbc; key_load = 1'b1;
    step();
    key_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] data, input logic last);
    logic hs;
    hs = 1'b0;
    s_valid = 1'b1; s_data = data; s_last = last;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = s_ready;
      step();
    end
    check("send_accepted", hs, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [127:0] exp_data, input logic exp_last);
    m_ready = 1'b1;
    for (int i = 0; i < 50 && !m_valid; i++) step();
    check({tag, "_valid"}, m_valid, 1'b1);
    check({tag, "_data"}, m_data, exp_data);
    check({tag, "_last"}, m_last, exp_last);
    step();
  endtask

  initial begin
    logic [127:0] bp_in [6];
    logic [127:0] bp_exp [6];
    logic         hs;
    int           got;
    int           stale;
    bp_in[0] = 128'h6bc1bee22e409f96e93d7e117393172a; bp_exp[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    bp_in[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; bp_exp[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    bp_in[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; bp_exp[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    bp_in[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; bp_exp[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
    bp_in[4] = 128'h3243f6a8885a308d313198a2e0370734; bp_exp[4] = 128'h3925841d02dc09fbdc118597196a0b32;
    bp_in[5] = 128'h6bc1bee22e409f96e93d7e117393172a; bp_exp[5] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    // Reset state
    step(); step();
    check("rst_sready_low", s_ready, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_sready", s_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_mvalid", m_valid, 1'b0);
    check("rst_mdata", m_data, 128'h0);
    check("rst_mlast", m_last, 1'b0);
    check("rst_keyerr", key_err, 1'b0);

    // ECB encrypt, config and block in the same idle cycle, latency of 2 edges
    key_in = K1; iv_in = '0; encrypt = 1'b1; cbc_mode = 1'b0; key_load = 1'b1;
    s_valid = 1'b1; s_data = 128'h00112233445566778899aabbccddeeff; s_last = 1'b1;
    step();
    key_load = 1'b0; s_valid = 1'b0;
    check("t1_busy", busy, 1'b1);
    check("t1_keyerr", key_err, 1'b0);
    step();
    check("t1_not_yet", m_valid, 1'b0);
    step();
    check("t1_valid", m_valid, 1'b1);
    check("t1_data", m_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("t1_last", m_last, 1'b1);
    step();
    check("t1_hold", m_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    m_ready = 1'b1;
    step();
    check("t1_drop", m_valid, 1'b0);
    check("t1_idle", busy, 1'b0);

    // ECB decrypt
    load_cfg(K1, '0, 1'b0, 1'b0);
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    recv("ecb_dec", 128'h00112233445566778899aabbccddeeff, 1'b1);

    // key_load while busy is rejected; result uses the old key
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
    key_in = K2; encrypt = 1'b1; key_load = 1'b1;
    check("kerr_busy", busy, 1'b1);
    step();
    key_load = 1'b0;
    check("kerr_pulse", key_err, 1'b1);
    step();
    check("kerr_clear", key_err, 1'b0);
    recv("kerr_oldkey", 128'h00112233445566778899aabbccddeeff, 1'b1);

    // FIPS-197 appendix B vector
    load_cfg(K2, '0, 1'b1, 1'b0);
    send(bp_in[4], 1'b0);
    recv("fips_b", bp_exp[4], 1'b0);

    // Backpressure: 4 queued + 1 held, then drain in order
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(bp_in[i], 1'b0);
    check("bp_sready_low", s_ready, 1'b0);
    check("bp_held_valid", m_valid, 1'b1);
    s_valid = 1'b1; s_data = bp_in[5]; s_last = 1'b1;
    step();
    check("bp_still_full", s_ready, 1'b0);
    check("bp_held_data", m_data, bp_exp[0]);
    m_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      hs = s_valid && s_ready;
      if (m_valid) begin
        check($sformatf("bp_data%0d", got), m_data, bp_exp[got]);
        check($sformatf("bp_last%0d", got), m_last, got == 5);
        got++;
      end
      step();
      if (hs) s_valid = 1'b0;
    end
    check("bp_count", got, 6);
    check("bp_idle", busy, 1'b0);

    // Reset during CALC with 3 blocks queued
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(bp_in[i], 1'b0);
    m_ready = 1'b1;
    step();
    check("rc_in_calc_busy", busy, 1'b1);
    check("rc_in_calc_mvalid", m_valid, 1'b0);
    rst = 1'b1;
    step();
    check("rc_mvalid", m_valid, 1'b0);
    check("rc_busy", busy, 1'b0);
    check("rc_sready", s_ready, 1'b0);
    check("rc_mdata", m_data, 128'h0);
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_valid) stale++;
    end
    check("rc_no_stale", stale, 0);
    check("rc_idle", busy, 1'b0);

    // Engine works again after reset
    load_cfg(K1, '0, 1'b1, 1'b0);
    send(128'h00112233445566778899aabbccddeeff, 1'b1);
    recv("post_rst", 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);

`ifdef AES_CBC_EN
    // CBC encrypt, IV restart after last, then CBC decrypt
    load_cfg(K2, IV, 1'b1, 1'b1);
    send(128'h6bc1bee22e409f96e93d7e117393172a, 1'b0);
    recv("cbc_e0", 128'h7649abac8119b246cee98e9b12e9197d, 1'b0);
    send(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
    recv("cbc_e1", 128'h5086cb9b507219ee95db113a917678b2, 1'b1);
    send(128'h6bc1bee22e409f96e93d7e117393172a, 1'b1);
    recv("cbc_restart", 128'h7649abac8119b246cee98e9b12e9197d, 1'b1);
    load_cfg(K2, IV, 1'b0, 1'b1);
    send(128'h7649abac8119b246cee98e9b12e9197d, 1'b0);
    recv("cbc_d0", 128'h6bc1bee22e409f96e93d7e117393172a, 1'b0);
    send(128'h5086cb9b507219ee95db113a917678b2, 1'b1);
    recv("cbc_d1", 128'hae2d8a571e03ac9c9eb76fac45af8e51, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_stream_engine.md
# aes_stream_engine

Parametrised streaming AES-128 engine: a successor to the single-shot AES top. It accepts a stream of 128-bit blocks over a valid/ready interface and queues them in an input FIFO. Each block goes through the combinational `aes_encrypt`/`aes_decrypt` cores with a configurable multicycle settle window, in ECB or CBC mode, and results are returned over a valid/ready output. The engine sits between the host DMA/bus adapter and the crypto cores and replaces per-block start/done polling.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: input queue depth in blocks. Power of 2, at least 2.
- `CORE_CYCLES`, default 1: clock cycles allowed for the combinational core to settle. At least 1.

Ports (`clk`, `rst`; one clock; reset is synchronous and active-high):
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `key_load` in 1: load the cfg fields below. Accepted only when idle.
- `key_in` in 128: AES-128 key.
- `iv_in` in 128: CBC initial vector.
- `encrypt` in 1: 1 = encrypt, 0 = decrypt.
- `cbc_mode` in 1: 1 = CBC, 0 = ECB.
- `key_err` out 1: one-cycle pulse when `key_load` is rejected.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 128, `s_last` in 1: input block stream. `s_last` marks the final block of a message.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 128, `m_last` out 1: output block stream.
- `busy` out 1: high when the FIFO is non-empty, the engine is in CALC, or `m_valid` is high.

## Operation
- Input FIFO:
  - Write on `s_valid && s_ready`; each entry stores {`s_last`, `s_data`}.
  - `s_ready = !full && !rst`.
  - Writes while full are impossible by construction. A push and a pop in the same cycle are both honoured.
- Config:
  - When `key_load` is high and `busy` is low, the next edge captures key, IV, `encrypt` and `cbc_mode`, and sets `chain <= iv_in`.
  - When `key_load` is high and `busy` is high, nothing changes and `key_err` pulses for 1 cycle.
  - If `key_load` and an `s` handshake occur in the same idle cycle, the new config applies to that block.
- FSM states and transitions:
  - IDLE:
    - FIFO non-empty: pop the head into `din_reg`/`last_reg`, load `cnt = CORE_CYCLES-1`, go to CALC.
  - CALC:
    - `cnt != 0`: decrement `cnt`.
    - `cnt == 0`: register the result into `m_data`/`m_last`, set `m_valid = 1`, update `chain`, go to OUT.
  - OUT (holds while `m_ready` is low; `m_data`/`m_last` stay stable):
    - `m_ready` high and FIFO non-empty: pop directly, go to CALC.
    - `m_ready` high and FIFO empty: go to IDLE.
    - In both cases `m_valid` drops unless a new result is registered.
- Datapath:
  - ECB: core input = `din_reg`; result = core output.
  - CBC encrypt: core input = `din_reg ^ chain`; result = C; `chain <= C`.
  - CBC decrypt: core input = `din_reg`; result = `D(din_reg) ^ chain`; `chain <= din_reg`.
  - When the block was `last`, `chain <= iv_reg` instead, so the next message restarts from the IV.
- Reset clears:
  - FSM to IDLE, FIFO flushed (count 0), `cnt` 0.
  - Key, IV and chain registers to 0.
  - Outputs: `m_valid` 0, `m_data` 0, `m_last` 0, `key_err` 0, `busy` 0, `s_ready` 0 while `rst` is high.
  - Reset mid-block discards all queued and in-flight data with no output.

## Timing
- Edge numbering:
  - A block accepted at edge E0 into an empty idle engine pops at E1.
  - `m_valid` rises after edge E(1+CORE_CYCLES), so latency is CORE_CYCLES+1 edges.
- Sustained throughput with `m_ready` held high is one block per CORE_CYCLES+1 cycles.
- `m_valid` never drops without an `m_ready` handshake.
- `busy` and `s_ready` are combinational from registered state; there are no combinational `s`-to-`m` paths.
- `key_err` is registered and is high for exactly one cycle per rejected request.

## Configuration
- With `AES_CBC_EN` defined: CBC supported; IV, chain and XOR logic are present.
- Without `AES_CBC_EN`: `cbc_mode` and `iv_in` are ignored, chain and IV registers are removed, and the engine operates in ECB only.

## Test plan
- ECB encrypt, CORE_CYCLES=1:
  - key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff
  - -> `m_data` 69c4e0d86a7b0430d8cdb78070b4c55a, `m_valid` after 2 edges.
- ECB decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a with the same key
  - -> 00112233445566778899aabbccddeeff.
- CBC encrypt (`AES_CBC_EN`):
  - key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f
  - blocks 6bc1bee22e409f96e93d7e117393172a, then ae2d8a571e03ac9c9eb76fac45af8e51 (`last`)
  - -> 7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2.
  - Resending the first block afterwards -> 7649abac... again (IV restart).
- Backpressure, FIFO_DEPTH=4, `m_ready=0`:
  - Push 6 blocks -> `s_ready` drops after the 5th (4 queued + 1 held).
  - Release `m_ready` -> all 6 outputs arrive in order.
- `key_load` while `busy=1` -> `key_err` pulses for 1 cycle; later outputs still use the old key.
- Assert `rst` during CALC with 3 blocks queued -> the next cycle `m_valid=0`, `busy=0`, and no stale output appears after reset release.
